// File: rtl/ula_74181_seq_if.sv
// rtl/ula_74181_seq_if.sv - start/ready/done handshake and operand/result bundle for ula_74181_seq
interface ula_74181_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             a_eq_b;
    logic             zero;

    modport master (
        output start, a, b, s, m, c_in,
        input  ready, busy, done, f, c_out, a_eq_b, zero
    );

    modport slave (
        input  start, a, b, s, m, c_in,
        output ready, busy, done, f, c_out, a_eq_b, zero
    );
endinterface

// File: rtl/ula_74181_seq.sv
// rtl/ula_74181_seq.sv - slice-serial 74181-style ALU, one SLICE_W slice per clock, LSB first
module ula_74181_seq #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    ula_74181_seq_if.slave     bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("ula_74181_seq: WIDTH must be a non-zero multiple of SLICE_W");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q, acc;
    logic [3:0]       s_q;
    logic             m_q;
    logic [WIDTH-1:0] f_q;
    logic             c_out_q, a_eq_b_q, zero_q;

    logic [WIDTH-1:0] l_full, p_full, q_full, acc_next;
    logic [SLICE_W-1:0] p_sl, q_sl, l_sl, r_sl;
    logic [SLICE_W:0]   sum;
    logic               carry_next;
    logic               last;

    // Full-width P/Q and logic terms are purely bitwise, so slicing them keeps the ripple exact.
    always_comb begin
        l_full = '0;
        p_full = a_q;
        q_full = '0;
        case (s_q)
            4'b0000: l_full = ~a_q;
            4'b0001: l_full = ~(a_q | b_q);
            4'b0010: l_full = ~a_q & b_q;
            4'b0011: l_full = '0;
            4'b0100: l_full = ~(a_q & b_q);
            4'b0101: l_full = ~b_q;
            4'b0110: l_full = a_q ^ b_q;
            4'b0111: l_full = a_q & ~b_q;
            4'b1000: l_full = ~a_q | b_q;
            4'b1001: l_full = ~(a_q ^ b_q);
            4'b1010: l_full = b_q;
            4'b1011: l_full = a_q & b_q;
            4'b1100: l_full = '1;
            4'b1101: l_full = a_q | ~b_q;
            4'b1110: l_full = a_q | b_q;
            default: l_full = a_q;
        endcase
        case (s_q)
            4'b0000: begin p_full = a_q;         q_full = '0;          end
            4'b0001: begin p_full = a_q | b_q;   q_full = '0;          end
            4'b0010: begin p_full = a_q | ~b_q;  q_full = '0;          end
            4'b0011: begin p_full = '0;          q_full = '1;          end
            4'b0100: begin p_full = a_q;         q_full = a_q & ~b_q;  end
            4'b0101: begin p_full = a_q | b_q;   q_full = a_q & ~b_q;  end
            4'b0110: begin p_full = a_q;         q_full = ~b_q;        end
            4'b0111: begin p_full = a_q & ~b_q;  q_full = '1;          end
            4'b1000: begin p_full = a_q;         q_full = a_q & b_q;   end
            4'b1001: begin p_full = a_q;         q_full = b_q;         end
            4'b1010: begin p_full = a_q | ~b_q;  q_full = a_q & b_q;   end
            4'b1011: begin p_full = a_q & b_q;   q_full = '1;          end
            4'b1100: begin p_full = a_q;         q_full = a_q;         end
            4'b1101: begin p_full = a_q | b_q;   q_full = a_q;         end
            4'b1110: begin p_full = a_q | ~b_q;  q_full = a_q;         end
            default: begin p_full = a_q;         q_full = '1;          end
        endcase
    end

    always_comb begin
        p_sl = '0;
        q_sl = '0;
        l_sl = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IW'(k)) begin
                p_sl = p_full[k*SLICE_W +: SLICE_W];
                q_sl = q_full[k*SLICE_W +: SLICE_W];
                l_sl = l_full[k*SLICE_W +: SLICE_W];
            end
        end
        sum        = {1'b0, p_sl} + {1'b0, q_sl} + {{SLICE_W{1'b0}}, carry};
        r_sl       = m_q ? l_sl : sum[SLICE_W-1:0];
        carry_next = m_q ? 1'b0 : sum[SLICE_W];
        acc_next   = acc;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IW'(k)) acc_next[k*SLICE_W +: SLICE_W] = r_sl;
        end
        last = (idx == IW'(NSLICE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            acc      <= '0;
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        s_q   <= bus.s;
                        m_q   <= bus.m;
                        carry <= bus.c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= carry_next;
                    if (last) begin
                        f_q      <= acc_next;
                        c_out_q  <= carry_next;
                        a_eq_b_q <= (a_q == b_q);
                        zero_q   <= (acc_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.f      = f_q;
    assign bus.c_out  = c_out_q;
    assign bus.a_eq_b = a_eq_b_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_ula_74181_seq.sv
// tb/tb_ula_74181_seq.sv - directed and random checks of ula_74181_seq against a full-width model
module tb_ula_74181_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ula_74181_seq_if #(.WIDTH(W)) bus ();

    ula_74181_seq #(.WIDTH(W), .SLICE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
        logic [W-1:0] p, q, l, ones;
        ones = '1;
        if (m) begin
            case (s)
                4'd0:  l = ~a;         4'd1:  l = ~(a | b);
                4'd2:  l = ~a & b;     4'd3:  l = '0;
                4'd4:  l = ~(a & b);   4'd5:  l = ~b;
                4'd6:  l = a ^ b;      4'd7:  l = a & ~b;
                4'd8:  l = ~a | b;     4'd9:  l = ~(a ^ b);
                4'd10: l = b;          4'd11: l = a & b;
                4'd12: l = ones;       4'd13: l = a | ~b;
                4'd14: l = a | b;      default: l = a;
            endcase
            return {1'b0, l};
        end
        case (s)
            4'd0:  begin p = a;      q = '0;     end
            4'd1:  begin p = a | b;  q = '0;     end
            4'd2:  begin p = a | ~b; q = '0;     end
            4'd3:  begin p = '0;     q = ones;   end
            4'd4:  begin p = a;      q = a & ~b; end
            4'd5:  begin p = a | b;  q = a & ~b; end
            4'd6:  begin p = a;      q = ~b;     end
            4'd7:  begin p = a & ~b; q = ones;   end
            4'd8:  begin p = a;      q = a & b;  end
            4'd9:  begin p = a;      q = b;      end
            4'd10: begin p = a | ~b; q = a & b;  end
            4'd11: begin p = a & b;  q = ones;   end
            4'd12: begin p = a;      q = a;      end
            4'd13: begin p = a | b;  q = a;      end
            4'd14: begin p = a | ~b; q = a;      end
            default: begin p = a;    q = ones;   end
        endcase
        return {1'b0, p} + {1'b0, q} + {{W{1'b0}}, cin};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; returns edges from the start-sampling edge to done (or 99 on timeout).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.c_in = cin; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        if (bus.done !== 1'b1) lat = 99;
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] s, input logic m, input logic cin);
        int lat;
        logic [W:0] r;
        r = model(a, b, s, m, cin);
        do_op(a, b, s, m, cin, lat);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_f"}, bus.f, r[W-1:0]);
        check({tag, "_cout"}, bus.c_out, r[W]);
        check({tag, "_zero"}, bus.zero, (r[W-1:0] == '0));
        check({tag, "_aeqb"}, bus.a_eq_b, (a == b));
        @(posedge clk); @(negedge clk);
        check({tag, "_ready"}, bus.ready, 1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb, held;
        int dones;

        bus.start = 0; bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 0; bus.c_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_f", bus.f, 0);
        check("rst_cout", bus.c_out, 0);
        check("rst_aeqb", bus.a_eq_b, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.ready, 1);
        rst = 0;

        // Add with explicit latency and handshake timing.
        do_op(16'h1234, 16'h0FCD, 4'b1001, 0, 0, lat);
        check("add_lat", lat, 4);
        check("add_f", bus.f, 16'h2201);
        check("add_cout", bus.c_out, 0);
        check("add_zero", bus.zero, 0);
        check("add_ready_in_done", bus.ready, 0);
        @(posedge clk); @(negedge clk);
        check("add_ready_back", bus.ready, 1);
        check("add_done_pulse", bus.done, 0);

        do_op(16'hFFFF, 16'h0000, 4'b0000, 0, 1, lat);
        check("ripple_f", bus.f, 16'h0000);
        check("ripple_cout", bus.c_out, 1);
        check("ripple_zero", bus.zero, 1);

        do_op(16'h0005, 16'h0007, 4'b0110, 0, 1, lat);
        check("sub57_f", bus.f, 16'hFFFE);
        check("sub57_cout", bus.c_out, 0);
        do_op(16'h0007, 16'h0005, 4'b0110, 0, 1, lat);
        check("sub75_f", bus.f, 16'h0002);
        check("sub75_cout", bus.c_out, 1);
        do_op(16'h0007, 16'h0005, 4'b0011, 0, 0, lat);
        check("ones_f", bus.f, 16'hFFFF);
        check("ones_cout", bus.c_out, 0);

        do_op(16'hF0F0, 16'hFF00, 4'b0110, 1, 0, lat);
        check("xor_f", bus.f, 16'h0FF0);
        check("xor_cout", bus.c_out, 0);
        do_op(16'hABCD, 16'hABCD, 4'b1111, 1, 1, lat);
        check("passa_f", bus.f, 16'hABCD);
        check("passa_aeqb", bus.a_eq_b, 1);
        check("passa_cout", bus.c_out, 0);
        @(posedge clk);

        for (int i = 0; i < 48; i++) begin
            ra = W'($urandom);
            rb = (i % 6 == 0) ? ra : W'($urandom);
            op_check($sformatf("rnd%0d", i), ra, rb, 4'($urandom), 1'($urandom), 1'($urandom));
        end
        op_check("last_carry", 16'h8000, 16'h8000, 4'b1001, 0, 0);

        // Inputs changed and start reasserted while busy must not disturb the latched operation.
        held = bus.f;
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.s = 4'b1001; bus.m = 0; bus.c_in = 1; bus.start = 1;
        @(posedge clk); @(negedge clk);
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.s = 4'b0011; bus.m = 1;
        check("hs_busy", bus.busy, 1);
        check("hs_hold1", bus.f, held);
        @(posedge clk); @(negedge clk);
        check("hs_hold2", bus.f, held);
        bus.start = 0;
        dones = 0; lat = 1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (bus.done === 1'b1) begin
                dones++;
                check("hs_lat", lat, 4);
                check("hs_f", bus.f, 16'h3334);
            end else if (dones == 0) begin
                check("hs_hold", bus.f, held);
            end
        end
        check("hs_one_done", dones, 1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        bus.a = 16'h0F0F; bus.b = 16'h0101; bus.s = 4'b1001; bus.m = 0; bus.c_in = 0; bus.start = 1;
        @(posedge clk); @(negedge clk);
        bus.start = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("mid_f", bus.f, 0);
        check("mid_cout", bus.c_out, 0);
        check("mid_ready", bus.ready, 1);
        check("mid_done", bus.done, 0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst = 0;
            if (bus.done === 1'b1) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_ready_after", bus.ready, 1);
        do_op(16'h0001, 16'h0001, 4'b1001, 0, 0, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_f", bus.f, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_74181_seq.md
Name: ula_74181_seq

Overview:
- Parametrised, slice-serial successor to the 4-bit 74181 ALU.
- Takes WIDTH-bit operands and evaluates the full 16-function logic/arithmetic set one SLICE_W-bit slice per clock, LSB slice first, with the carry held in a flop between slices.
- Start/ready/done handshake; operands latched at start; results registered and held until the next completion.
- Sits wherever a wide ALU is needed but area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE_W (elaboration error otherwise).
- SLICE_W, 4, bits processed per clock.
- NSLICE, WIDTH/SLICE_W (local), number of slice cycles per operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request an operation; sampled only when ready=1.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select.
- m  in  1  mode: 1 = logic, 0 = arithmetic.
- c_in  in  1  carry-in, active-high.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- f  out  WIDTH  result.
- c_out  out  1  carry out of bit WIDTH-1; always 0 in logic mode.
- a_eq_b  out  1  latched A equals latched B, full width.
- zero  out  1  f is all zeros.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, slice index=0, carry flop=0.
  - f=0, c_out=0, a_eq_b=0, zero=0, done=0, busy=0, ready=1.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1: latch a, b, s, m, c_in; carry flop <= c_in; index <= 0; go to RUN.
  - On an edge with start=0: stay in IDLE.
- RUN (NSLICE cycles):
  - Each edge computes slice[index] from latched operands and the carry flop; writes it into the internal accumulator and updates the carry flop.
  - If index==NSLICE-1: go to DONE and register f, c_out, a_eq_b and zero (zero computed from the final result).
  - Otherwise: index++.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - done is high during the cycle after the NSLICE-th edge following the start-sampling edge.
  - ready returns one edge later.
  - One operation per NSLICE+2 cycles.
- Output stability: f, c_out, a_eq_b and zero change only on the edge that enters DONE (and on reset); otherwise they hold the previous result.
- Input changes after the start edge have no effect on the operation in flight.
- start while busy is ignored, not queued.
- Logic mode (m=1), bitwise over WIDTH, by s:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 all zeros.
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B.
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B.
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A.
  - c_out=0; the carry chain is unused.
- Arithmetic mode (m=0): result = P + Q + c_in, with ones = all-ones. {c_out,f} is the WIDTH+1-bit sum. P,Q by s:
  - 0000 A,0; 0001 A|B,0; 0010 A|~B,0; 0011 0,ones.
  - 0100 A,A&~B; 0101 A|B,A&~B; 0110 A,~B; 0111 A&~B,ones.
  - 1000 A,A&B; 1001 A,B; 1010 A|~B,A&B; 1011 A&B,ones.
  - 1100 A,A; 1101 A|B,A; 1110 A|~B,A; 1111 A,ones.
  - P and Q are bitwise, so the slice-serial ripple is exact.
  - c_out=1 means no borrow for subtract forms.
- Reset mid-operation: aborts immediately, no done pulse, all outputs cleared per the reset values; the next start after reset release runs normally.

Test Plan (WIDTH=16, NSLICE=4):
- Add: m=0, s=1001, a=0x1234, b=0x0FCD, c_in=0 -> f=0x2201, c_out=0, zero=0. done high exactly 4 edges after the start-sampling edge; ready back 1 edge later.
- Full carry ripple: m=0, s=0000, a=0xFFFF, c_in=1 -> f=0x0000, c_out=1, zero=1.
- Subtract: m=0, s=0110, c_in=1.
  - a=0x0005, b=0x0007 -> f=0xFFFE, c_out=0.
  - a=0x0007, b=0x0005 -> f=0x0002, c_out=1.
  - s=0011, c_in=0 -> f=0xFFFF, c_out=0.
- Logic mode:
  - m=1, s=0110, a=0xF0F0, b=0xFF00 -> f=0x0FF0, c_out=0.
  - m=1, s=1111, a=b=0xABCD -> f=0xABCD, a_eq_b=1.
- Handshake: pulse start, then change a/b and reassert start during RUN -> result matches the originally latched operands; only one done pulse; previous f held until that done.
- Reset mid-run: assert rst during the 2nd RUN cycle -> f=0, c_out=0, done never pulses, ready=1. A following add 0x0001+0x0001 -> f=0x0002.
